mem_dump_reader: RTL

- Read-side counterpart to the boot-time program loader. The loader writes program words into memory; this block reads a word range back from memory.
- It serializes each word into a little-endian byte stream (byte 0 = bits [7:0] first), matching the loader's byte order.
- The stream feeds the debug/console byte sink, for post-load dump and host-side comparison against run.hex.
- It sits between the unified memory read port and the byte-stream TX path. It is idle until started by the top level after loading_done.

---
 rtl/mem_dump_reader_pkg.sv | 32 +++
 rtl/mem_dump_reader_if.sv | 29 ++
 rtl/mem_dump_reader_word_serializer.sv | 45 ++++
 rtl/mem_dump_reader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_reader_pkg.sv
// Shared constants and FSM encoding for the memory dump reader (also used by the program loader).
// MEM_DUMP_CHECKSUM_EN adds the CKSUM state used for the checksum trailer.
package mem_dump_pkg;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned DEFAULT_MAX_WORDS = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_FIN   = 3'd4
`ifdef MEM_DUMP_CHECKSUM_EN
        ,
        ST_CKSUM = 3'd5
`endif
    } state_t;

    function automatic logic [31:0] clamp_count(input logic [31:0] requested,
                                                input logic [31:0] limit);
        logic [31:0] result;
        if (requested > limit) begin
            result = limit;
        end else begin
            result = requested;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_dump_reader_if.sv
// Control, memory read port and byte stream of the dump reader bundled as one interface.
// master = the dump reader, slave = top level / memory / byte sink side.
interface mem_dump_reader_if;

    logic        start;
    logic [31:0] word_count;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;
    logic        truncated;
    logic [31:0] checksum;

    modport master (
        input  start, word_count, mem_ack, mem_rdata, byte_ready,
        output mem_addr, mem_re, byte_data, byte_valid, busy, done, truncated, checksum
    );

    modport slave (
        output start, word_count, mem_ack, mem_rdata, byte_ready,
        input  mem_addr, mem_re, byte_data, byte_valid, busy, done, truncated, checksum
    );

endinterface

// File: rtl/mem_dump_reader_word_serializer.sv
// 32-bit to 8-bit little-endian serializer with valid/ready output and a 2-bit byte counter.
// last_fire flags the handshake of the fourth byte so the caller can chain the next word.
module word_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        last_fire
);

    logic [31:0] shift_r;
    logic [1:0]  idx_r;
    logic        valid_r;
    logic        fire_s;

    assign fire_s     = valid_r & byte_ready;
    assign last_fire  = fire_s & (idx_r == 2'd3);
    assign byte_data  = shift_r[7:0];
    assign byte_valid = valid_r;

    // Shift register: load wins over a handshake so a trailer word can follow back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= 32'h0000_0000;
            idx_r   <= 2'd0;
            valid_r <= 1'b0;
        end else if (load) begin
            shift_r <= load_data;
            idx_r   <= 2'd0;
            valid_r <= 1'b1;
        end else if (fire_s) begin
            shift_r <= {8'h00, shift_r[31:8]};
            idx_r   <= idx_r + 2'd1;
            valid_r <= (idx_r != 2'd3);
        end else begin
            shift_r <= shift_r;
            idx_r   <= idx_r;
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Reads a word range back from memory and streams it out little-endian for host-side comparison.
// Optional MEM_DUMP_CHECKSUM_EN: running word checksum plus a 4-byte trailer before FIN.
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    mem_dump_reader_if.master bus
);

    localparam logic [31:0] MAX_WORDS_C = 32'(MAX_WORDS);
    localparam logic [31:0] WORD_STRIDE = 32'(BYTES_PER_WORD);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] count_r;
    logic [31:0] words_done_r;
    logic [31:0] mem_addr_r;
    logic [31:0] clamped_s;
    logic        mem_re_r;
    logic        busy_r;
    logic        done_r;
    logic        truncated_r;
    logic        accept_s;
    logic        capture_s;
    logic        next_word_s;
    logic        to_fin_s;
    logic        ser_load_s;
    logic [31:0] ser_load_data_s;
    logic        last_fire_s;
    logic [7:0]  ser_byte_s;
    logic        ser_valid_s;

    assign clamped_s = clamp_count(bus.word_count, MAX_WORDS_C);

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Modulo-2^32 sum of every captured word, restarted by each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_r <= 32'h0000_0000;
        end else if (accept_s) begin
            checksum_r <= 32'h0000_0000;
        end else if (capture_s) begin
            checksum_r <= checksum_r + bus.mem_rdata;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign bus.checksum = checksum_r;
`else
    assign bus.checksum = 32'h0000_0000;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and one-cycle control strobes for the datapath.
    always_comb begin
        next_state_s    = state_r;
        accept_s        = 1'b0;
        capture_s       = 1'b0;
        next_word_s     = 1'b0;
        to_fin_s        = 1'b0;
        ser_load_s      = 1'b0;
        ser_load_data_s = bus.mem_rdata;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    if (clamped_s == 32'd0) begin
                        to_fin_s     = 1'b1;
                        next_state_s = ST_FIN;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (mem_re_r && bus.mem_ack) begin
                    capture_s    = 1'b1;
                    ser_load_s   = 1'b1;
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_SHIFT: begin
                if (last_fire_s) begin
                    if ((words_done_r + 32'd1) < count_r) begin
                        next_word_s  = 1'b1;
                        next_state_s = ST_REQ;
                    end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        ser_load_s      = 1'b1;
                        ser_load_data_s = checksum_r;
                        next_state_s    = ST_CKSUM;
`else
                        to_fin_s     = 1'b1;
                        next_state_s = ST_FIN;
`endif
                    end
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            ST_CKSUM: begin
                if (last_fire_s) begin
                    to_fin_s     = 1'b1;
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_CKSUM;
                end
            end
`endif
            ST_FIN: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Request/address/word bookkeeping; mem_re stays up until the ack cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r      <= 32'd0;
            words_done_r <= 32'd0;
            mem_addr_r   <= BASE_ADDR;
            mem_re_r     <= 1'b0;
            truncated_r  <= 1'b0;
        end else if (accept_s) begin
            count_r      <= clamped_s;
            words_done_r <= 32'd0;
            mem_addr_r   <= BASE_ADDR;
            mem_re_r     <= (clamped_s != 32'd0);
            truncated_r  <= (bus.word_count > MAX_WORDS_C);
        end else if (capture_s) begin
            mem_re_r <= 1'b0;
        end else if (next_word_s) begin
            words_done_r <= words_done_r + 32'd1;
            mem_addr_r   <= mem_addr_r + WORD_STRIDE;
            mem_re_r     <= 1'b1;
        end else begin
            mem_re_r <= mem_re_r;
        end
    end

    // Status flags: done/busy follow FIN entry, an accepted start re-arms them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (to_fin_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
        end else if (accept_s) begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_r;
            done_r <= done_r;
        end
    end

    word_serializer u_serializer (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load_s),
        .load_data  (ser_load_data_s),
        .byte_ready (bus.byte_ready),
        .byte_data  (ser_byte_s),
        .byte_valid (ser_valid_s),
        .last_fire  (last_fire_s)
    );

    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_re     = mem_re_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.truncated  = truncated_r;
    assign bus.byte_data  = ser_byte_s;
    assign bus.byte_valid = ser_valid_s;

endmodule
